// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters. It predicts the next PC in the
// same cycle and is trained by resolved conditional branches. Two statistics counters saturate.
module branch_predictor #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fetch_pc,
  output logic              predict_taken,
  output logic [DATA_W-1:0] predict_pc,
  input  logic              update_valid,
  input  logic [DATA_W-1:0] update_pc,
  input  logic              update_taken,
  input  logic [DATA_W-1:0] update_target,
  input  logic              update_predicted,
  output logic              mispredict,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_mispredicts
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = DATA_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid;
  logic [1:0]         ctr     [ENTRIES];
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [DATA_W-1:0]  tgt_mem [ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit;
  logic             unused_pc_lsb;

  function automatic logic [1:0] ctr_sat(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    else    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Lookup: purely combinational from the registered table, with no bypass of a same-cycle update
  assign f_idx         = fetch_pc[IDX_W+1:2];
  assign f_tag         = fetch_pc[DATA_W-1:IDX_W+2];
  assign f_hit         = valid[f_idx] && (tag_mem[f_idx] == f_tag);
  assign predict_taken = f_hit && ctr[f_idx][1];
  assign predict_pc    = predict_taken ? tgt_mem[f_idx] : fetch_pc + DATA_W'(4);

  assign u_idx         = update_pc[IDX_W+1:2];
  assign u_tag         = update_pc[DATA_W-1:IDX_W+2];
  assign u_hit         = valid[u_idx] && (tag_mem[u_idx] == u_tag);
  assign mispredict    = update_valid && (update_taken != update_predicted);
  assign unused_pc_lsb = ^update_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid            <= '0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (update_valid) begin
      stat_branches <= cnt_sat(stat_branches);
      if (mispredict) stat_mispredicts <= cnt_sat(stat_mispredicts);
      if (u_hit) begin
        ctr[u_idx] <= ctr_sat(ctr[u_idx], update_taken);
      end else if (update_taken) begin
        valid[u_idx] <= 1'b1;
        ctr[u_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target storage has no reset; valid gates its use. A write on a hit rewrites the same tag
  always_ff @(posedge clk) begin
    if (!rst && update_valid && update_taken) begin
      tag_mem[u_idx] <= u_tag;
      tgt_mem[u_idx] <= update_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded bench for branch_predictor. A table-level reference model predicts every cycle's
// outputs, and a monitor compares them on the falling edge.
module tb_branch_predictor;
  localparam int DATA_W  = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 16;
  localparam int ENTRIES = 1 << IDX_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int PC_MOD  = 1 << DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] fetch_pc = '0;
  logic              predict_taken;
  logic [DATA_W-1:0] predict_pc;
  logic              update_valid = 1'b0;
  logic [DATA_W-1:0] update_pc = '0;
  logic              update_taken = 1'b0;
  logic [DATA_W-1:0] update_target = '0;
  logic              update_predicted = 1'b0;
  logic              mispredict;
  logic [CNT_W-1:0]  stat_branches;
  logic [CNT_W-1:0]  stat_mispredicts;

  always #5 clk = ~clk;

  branch_predictor #(.DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
    .predict_taken(predict_taken), .predict_pc(predict_pc),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_predicted(update_predicted),
    .mispredict(mispredict), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  typedef struct {
    bit pt;
    int ppc;
    bit mp;
    int sb;
    int sm;
  } exp_t;

  exp_t sbq[$];

  // Reference model: one record per BTB slot plus two plain integer statistics
  bit m_v   [ENTRIES];
  int m_tag [ENTRIES];
  int m_tgt [ENTRIES];
  int m_ctr [ENTRIES];
  int m_br, m_mp;

  int checks = 0;
  int fails  = 0;

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_v[i]   = 1'b0;
      m_ctr[i] = 1;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int rand_pc();
    if ($urandom_range(0, 15) == 0) return int'($urandom_range(0, PC_MOD - 1));
    return ($urandom_range(0, 3) << (IDX_W + 2)) | ($urandom_range(0, ENTRIES - 1) << 2)
           | $urandom_range(0, 3);
  endfunction

  // Drive one cycle and queue its expected outputs. The model then applies the edge's effect.
  task automatic cycle(input bit r, input int fpc, input bit uv, input int upc,
                       input bit ut, input int utgt, input bit up);
    exp_t e;
    int   fi, ft, ui, utag;
    bit   fh, uh;
    @(posedge clk);
    #1;
    rst              = r;
    fetch_pc         = fpc[DATA_W-1:0];
    update_valid     = uv;
    update_pc        = upc[DATA_W-1:0];
    update_taken     = ut;
    update_target    = utgt[DATA_W-1:0];
    update_predicted = up;

    fi    = (fpc >> 2) % ENTRIES;
    ft    = fpc >> (IDX_W + 2);
    fh    = m_v[fi] && (m_tag[fi] == ft);
    e.pt  = fh && (m_ctr[fi] >= 2);
    e.ppc = e.pt ? m_tgt[fi] : (fpc + 4) % PC_MOD;
    e.mp  = uv && (ut != up);
    e.sb  = m_br;
    e.sm  = m_mp;
    sbq.push_back(e);

    if (r) begin
      model_reset();
    end else if (uv) begin
      ui   = (upc >> 2) % ENTRIES;
      utag = upc >> (IDX_W + 2);
      uh   = m_v[ui] && (m_tag[ui] == utag);
      m_br = (m_br < CNT_MAX) ? m_br + 1 : CNT_MAX;
      if (e.mp) m_mp = (m_mp < CNT_MAX) ? m_mp + 1 : CNT_MAX;
      if (uh && ut) begin
        m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
        m_tgt[ui] = utgt;
      end else if (uh) begin
        m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
      end else if (ut) begin
        m_v[ui]   = 1'b1;
        m_tag[ui] = utag;
        m_tgt[ui] = utgt;
        m_ctr[ui] = 2;
      end
    end
  endtask

  task automatic look(input int fpc);
    cycle(1'b0, fpc, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic upd(input int fpc, input int upc, input bit ut, input int utgt, input bit up);
    cycle(1'b0, fpc, 1'b1, upc, ut, utgt, up);
  endtask

  task automatic do_reset();
    cycle(1'b1, 'h0040, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("predict_taken", int'(predict_taken), int'(e.pt));
        check("predict_pc", int'(predict_pc), e.ppc);
        check("mispredict", int'(mispredict), int'(e.mp));
        check("stat_branches", int'(stat_branches), e.sb);
        check("stat_mispredicts", int'(stat_mispredicts), e.sm);
      end
    end
  end

  initial begin : stimulus
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);

    // Reset state, then first allocation and its visibility one cycle later
    look('h0040);
    upd('h0040, 'h0040, 1'b1, 'h0010, 1'b0);
    look('h0040);
    // Hysteresis: saturate to strong taken, then two not-taken updates to fall back to not-taken
    upd('h0040, 'h0040, 1'b1, 'h0010, 1'b1);
    upd('h0040, 'h0040, 1'b1, 'h0010, 1'b1);
    upd('h0040, 'h0040, 1'b0, 'h0000, 1'b1);
    look('h0040);
    upd('h0040, 'h0040, 1'b0, 'h0000, 1'b1);
    look('h0040);
    // Aliasing on index 0
    upd('h0040, 'h0040, 1'b1, 'h0010, 1'b0);
    upd('h0040, 'h0080, 1'b1, 'h0020, 1'b0);
    look('h0040);
    look('h0080);
    // Same-cycle lookup and update without bypass; a not-taken miss does not allocate
    do_reset();
    upd('h0040, 'h0040, 1'b1, 'h0030, 1'b0);
    look('h0040);
    do_reset();
    upd('h0040, 'h0040, 1'b0, 'h0030, 1'b0);
    look('h0040);
    look('hFFFC);

    for (int i = 0; i < 3000; i++) begin
      int pick;
      pick = rand_pc();
      cycle($urandom_range(0, 63) == 0, rand_pc(), $urandom_range(0, 3) != 0, pick,
            $urandom_range(0, 1) == 1, int'($urandom_range(0, PC_MOD - 1)),
            $urandom_range(0, 1) == 1);
    end

    // Counter saturation, followed by a reset that collides with an update
    do_reset();
    for (int i = 0; i < CNT_MAX + 4; i++)
      upd(rand_pc(), rand_pc(), 1'b1, int'($urandom_range(0, PC_MOD - 1)), 1'b0);
    look('h0040);
    cycle(1'b1, 'h0040, 1'b1, 'h0040, 1'b1, 'h0010, 1'b0);
    look('h0040);
    look('hFFFC);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the pipelined core, sitting beside the fetch stage and fed back from the branch-resolution logic in execute. It holds a direct-mapped branch target buffer (BTB) of tag, target and 2-bit saturating counter per entry. Each cycle it predicts the next PC for the instruction being fetched. When a conditional branch resolves, it updates the entry with the actual outcome and the resolved target, and counts branches and mispredictions.

## Interface
Parameters:
- DATA_W, 16, width of PCs and targets.
- IDX_W, 4, index bits; the BTB has 2^IDX_W entries.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- fetch_pc  input  DATA_W  PC of the instruction being fetched this cycle.
- predict_taken  output  1  1 = fetch_pc is predicted to be a taken branch.
- predict_pc  output  DATA_W  predicted next PC.
- update_valid  input  1  a conditional branch resolves this cycle.
- update_pc  input  DATA_W  PC of the resolving branch.
- update_taken  input  1  actual outcome: 1 = taken.
- update_target  input  DATA_W  resolved taken-target of the branch.
- update_predicted  input  1  the prediction that was carried down the pipe with this branch.
- mispredict  output  1  update_valid and (update_taken != update_predicted); combinational.
- stat_branches  output  CNT_W  number of accepted updates.
- stat_mispredicts  output  CNT_W  number of mispredicted updates.

## Operation
- Index: pc[IDX_W+1:2]. Tag: pc[DATA_W-1:IDX_W+2]. PC bits [1:0] are ignored.
- Each entry holds: valid (1), tag, target (DATA_W), ctr (2).
- ctr encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Lookup is combinational from registered state:
  - hit = valid[idx] and tag match.
  - predict_taken = hit and ctr[1].
  - predict_pc = predict_taken ? target : fetch_pc + 4, computed modulo 2^DATA_W, so wrap-around is allowed.
- Update on the clock edge when update_valid = 1:
  - Hit, taken: ctr increments, saturating at 11; target is set to update_target.
  - Hit, not taken: ctr decrements, saturating at 00; target is unchanged.
  - Miss, taken: the entry is allocated or overwritten. valid = 1, tag and target are written, ctr = 10.
  - Miss, not taken: the table is unchanged.
- Statistics, only when update_valid = 1:
  - stat_branches increments by 1.
  - stat_mispredicts increments by 1 when mispredict = 1.
  - Both counters saturate at all-ones and do not wrap.
- update_predicted is used only for the statistics and for mispredict. It never affects table contents. Redirecting the PC on a misprediction is the job of the fetch logic.

## Timing
- Prediction has zero latency: predict_* follow fetch_pc in the same cycle.
- An update becomes visible to lookups in the cycle after the edge that writes it.
- A lookup and an update to the same index in the same cycle: the lookup returns the pre-update contents. There is no bypass.
- Reset:
  - All valid bits = 0, all ctr = 01.
  - Both stat counters = 0.
  - Consequently predict_taken = 0 and predict_pc = fetch_pc + 4.
  - rst has priority over a simultaneous update; that update is dropped and is not counted.
  - Tag and target contents need not be reset.
- rst asserted mid-run clears the table and counters on the next edge. Predictions from the following cycle are not-taken.

## Test plan
- Reset, then fetch_pc = 0x0040 -> predict_taken = 0, predict_pc = 0x0044, both stats = 0.
- One update with pc = 0x0040, taken = 1, target = 0x0010, predicted = 0; next cycle fetch_pc = 0x0040 -> predict_taken = 1, predict_pc = 0x0010; mispredict was 1 during the update cycle; stat_mispredicts = 1.
- Hysteresis on pc 0x0040: three taken updates (ctr reaches 11), then one not-taken update -> still predicted taken. A second not-taken update -> predict_pc = 0x0044.
- Aliasing: allocate pc 0x0040, then a taken update for pc 0x0080 (same index, different tag) -> lookup of 0x0040 misses and predicts 0x0044; lookup of 0x0080 hits.
- Same-cycle lookup and update for pc 0x0040 on an empty table -> not-taken that cycle, taken the next cycle. A not-taken update on a miss leaves the table unallocated.
- Boundaries:
  - fetch_pc = 0xFFFC on a miss -> predict_pc = 0x0000.
  - Drive 2^CNT_W + 3 mispredicted updates -> both counters hold 0xFFFF.
  - Assert rst together with an update -> all state is cleared and the update is not counted.
